// File: rtl/pipelined_addsub_pkg.sv
// Shared definitions for the pipelined adder/subtractor: flag bit positions,
// operation encoding and the slice-width helper.
package adder_pkg;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  function automatic int chunk_width(int width, int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/pipelined_addsub_if.sv
// Operand/result stream bundle for pipelined_addsub.
// Handshake: a beat transfers on a rising edge where valid and ready are both high;
// the sender holds valid and its data steady until that edge, and valid never waits on ready.
interface pipelined_addsub_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic [3:0]       out_flags;

  modport master (
    output in_valid, in_a, in_b, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_flags
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_flags
  );
endinterface

// File: rtl/pipelined_addsub_slice.sv
// One carry-chain slice: W-bit add of two operands with carry in and carry out.
module addsub_slice #(
  parameter int W = 16
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         c_i,
  output logic [W-1:0] s_o,
  output logic         c_o
);
  assign {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, c_i};
endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement add/subtract with NZCV flags; one carry-chain slice
// per stage, global stall on output backpressure.
module pipelined_addsub
  import adder_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic                clk,
  input  logic                reset,
  pipelined_addsub_if.slave   bus
);
  localparam int CHUNK = chunk_width(WIDTH, STAGES);

  logic              advance;
  logic              sub_op;
  logic [STAGES-1:0] valid_q;

  assign sub_op        = (bus.in_sub == OP_SUB);
  assign bus.out_valid = valid_q[STAGES-1];
  assign advance       = ~bus.out_valid | bus.out_ready;
  assign bus.in_ready  = advance;

  // Bubbles are carried, not squeezed out: every stage moves together.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else if (advance) begin
      valid_q[0] <= bus.in_valid;
      for (int k = 1; k < STAGES; k++) valid_q[k] <= valid_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // a_rem/b_rem hold only the operand chunks this stage and later ones still need.
    localparam int REM = WIDTH - k * CHUNK;

    logic [REM-1:0]         a_rem;
    logic [REM-1:0]         b_rem;
    logic                   c_in;
    logic [CHUNK-1:0]       chunk_sum;
    logic                   chunk_cout;
    logic [(k+1)*CHUNK-1:0] s_d;
    logic [(k+1)*CHUNK-1:0] s_q;

    if (k == 0) begin : g_head
      assign a_rem = bus.in_a;
      assign b_rem = bus.in_b ^ {WIDTH{sub_op}};
      assign c_in  = sub_op;
      assign s_d   = chunk_sum;
    end else begin : g_body
      assign a_rem = g_stage[k-1].g_fwd.a_q;
      assign b_rem = g_stage[k-1].g_fwd.b_q;
      assign c_in  = g_stage[k-1].g_fwd.c_q;
      assign s_d   = {chunk_sum, g_stage[k-1].s_q};
    end

    addsub_slice #(.W(CHUNK)) u_slice (
      .a_i (a_rem[CHUNK-1:0]),
      .b_i (b_rem[CHUNK-1:0]),
      .c_i (c_in),
      .s_o (chunk_sum),
      .c_o (chunk_cout)
    );

    always_ff @(posedge clk) begin
      if (reset)        s_q <= '0;
      else if (advance) s_q <= s_d;
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [REM-CHUNK-1:0] a_q;
      logic [REM-CHUNK-1:0] b_q;
      logic                 c_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          a_q <= '0;
          b_q <= '0;
          c_q <= 1'b0;
        end else if (advance) begin
          a_q <= a_rem[REM-1:CHUNK];
          b_q <= b_rem[REM-1:CHUNK];
          c_q <= chunk_cout;
        end
      end
    end else begin : g_tail
      logic [3:0] flags_d;
      logic [3:0] flags_q;

      // Overflow uses the operand sign bits after the subtract inversion.
      always_comb begin
        flags_d         = '0;
        flags_d[FLAG_N] = s_d[WIDTH-1];
        flags_d[FLAG_Z] = (s_d == '0);
        flags_d[FLAG_C] = chunk_cout;
        flags_d[FLAG_V] = (a_rem[CHUNK-1] == b_rem[CHUNK-1]) & (s_d[WIDTH-1] != a_rem[CHUNK-1]);
      end

      always_ff @(posedge clk) begin
        if (reset)        flags_q <= '0;
        else if (advance) flags_q <= flags_d;
      end
    end
  end

  assign bus.out_sum   = g_stage[STAGES-1].s_q;
  assign bus.out_flags = g_stage[STAGES-1].g_tail.flags_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: a 64-bit/4-stage instance and an 8-bit/1-stage instance,
// each scored against a reference model through an expected-result queue.
module tb_pipelined_addsub;
  import adder_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   pops64 = 0;

  logic [67:0] exp_q64[$];
  logic [11:0] exp_q8[$];

  pipelined_addsub_if #(.WIDTH(64)) bus64();
  pipelined_addsub_if #(.WIDTH(8))  bus8();

  pipelined_addsub #(.WIDTH(64), .STAGES(4)) u_dut64 (.clk(clk), .reset(rst), .bus(bus64));
  pipelined_addsub #(.WIDTH(8),  .STAGES(1)) u_dut8  (.clk(clk), .reset(rst), .bus(bus8));

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [67:0] model64(logic [63:0] a, logic [63:0] b, logic sub);
    logic [63:0] bb;
    logic [64:0] full;
    logic [3:0]  f;
    bb        = sub ? ~b : b;
    full      = {1'b0, a} + {1'b0, bb} + 65'(sub);
    f         = '0;
    f[FLAG_N] = full[63];
    f[FLAG_Z] = (full[63:0] == 64'd0);
    f[FLAG_C] = full[64];
    f[FLAG_V] = (a[63] == bb[63]) && (full[63] != a[63]);
    return {f, full[63:0]};
  endfunction

  function automatic logic [11:0] model8(logic [7:0] a, logic [7:0] b, logic sub);
    logic [7:0] bb;
    logic [8:0] full;
    logic [3:0] f;
    bb        = sub ? ~b : b;
    full      = {1'b0, a} + {1'b0, bb} + 9'(sub);
    f         = '0;
    f[FLAG_N] = full[7];
    f[FLAG_Z] = (full[7:0] == 8'd0);
    f[FLAG_C] = full[8];
    f[FLAG_V] = (a[7] == bb[7]) && (full[7] != a[7]);
    return {f, full[7:0]};
  endfunction

  // ---------------- scoreboard monitors ----------------
  always @(negedge clk) begin
    if (!rst && bus64.out_valid && bus64.out_ready) begin
      checks++;
      if (exp_q64.size() == 0) begin
        errors++;
        $display("FAIL sb64_unexpected got %h_%h exp none", bus64.out_flags, bus64.out_sum);
      end else begin
        logic [67:0] e;
        e = exp_q64.pop_front();
        pops64++;
        if ({bus64.out_flags, bus64.out_sum} !== e) begin
          errors++;
          $display("FAIL sb64 got flags %b sum %h exp flags %b sum %h",
                   bus64.out_flags, bus64.out_sum, e[67:64], e[63:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && bus8.out_valid && bus8.out_ready) begin
      checks++;
      if (exp_q8.size() == 0) begin
        errors++;
        $display("FAIL sb8_unexpected got %h_%h exp none", bus8.out_flags, bus8.out_sum);
      end else begin
        logic [11:0] e;
        e = exp_q8.pop_front();
        if ({bus8.out_flags, bus8.out_sum} !== e) begin
          errors++;
          $display("FAIL sb8 got flags %b sum %h exp flags %b sum %h",
                   bus8.out_flags, bus8.out_sum, e[11:8], e[7:0]);
        end
      end
    end
  end

  // ---------------- driver tasks (entered and left #1 after a rising edge) ----------------
  task automatic send64(input logic [63:0] a, input logic [63:0] b, input logic sub);
    bit acc;
    acc = 0;
    bus64.in_valid = 1'b1;
    bus64.in_a     = a;
    bus64.in_b     = b;
    bus64.in_sub   = sub;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus64.in_ready) begin
        acc = 1;
        break;
      end
      @(posedge clk); #1;
    end
    if (acc) begin
      exp_q64.push_back(model64(a, b, sub));
      @(posedge clk); #1;
    end else begin
      checks++;
      errors++;
      $display("FAIL send64_timeout got in_ready 0 exp 1 within 200 cycles");
    end
    bus64.in_valid = 1'b0;
  endtask

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic sub);
    bit acc;
    acc = 0;
    bus8.in_valid = 1'b1;
    bus8.in_a     = a;
    bus8.in_b     = b;
    bus8.in_sub   = sub;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus8.in_ready) begin
        acc = 1;
        break;
      end
      @(posedge clk); #1;
    end
    if (acc) begin
      exp_q8.push_back(model8(a, b, sub));
      @(posedge clk); #1;
    end else begin
      checks++;
      errors++;
      $display("FAIL send8_timeout got in_ready 0 exp 1 within 200 cycles");
    end
    bus8.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300; i++) begin
      if (exp_q64.size() == 0 && exp_q8.size() == 0) break;
      @(posedge clk); #1;
    end
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (exp_q64.size() != 0 || exp_q8.size() != 0) begin
      errors++;
      $display("FAIL drain got pending %0d/%0d exp 0/0", exp_q64.size(), exp_q8.size());
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst             = 1'b1;
    bus64.in_valid  = 1'b0; bus64.in_a = '0; bus64.in_b = '0; bus64.in_sub = 1'b0;
    bus64.out_ready = 1'b1;
    bus8.in_valid   = 1'b0; bus8.in_a = '0;  bus8.in_b = '0;  bus8.in_sub = 1'b0;
    bus8.out_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (bus64.in_ready !== 1'b1)   begin errors++; $display("FAIL rst64_in_ready got %b exp 1", bus64.in_ready); end
    checks++; if (bus64.out_valid !== 1'b0)  begin errors++; $display("FAIL rst64_out_valid got %b exp 0", bus64.out_valid); end
    checks++; if (bus64.out_sum !== 64'd0)   begin errors++; $display("FAIL rst64_sum got %h exp 0", bus64.out_sum); end
    checks++; if (bus64.out_flags !== 4'd0)  begin errors++; $display("FAIL rst64_flags got %b exp 0000", bus64.out_flags); end
    checks++; if (bus8.in_ready !== 1'b1)    begin errors++; $display("FAIL rst8_in_ready got %b exp 1", bus8.in_ready); end
    checks++; if (bus8.out_valid !== 1'b0)   begin errors++; $display("FAIL rst8_out_valid got %b exp 0", bus8.out_valid); end
    checks++; if (bus8.out_sum !== 8'd0)     begin errors++; $display("FAIL rst8_sum got %h exp 0", bus8.out_sum); end
    checks++; if (bus8.out_flags !== 4'd0)   begin errors++; $display("FAIL rst8_flags got %b exp 0000", bus8.out_flags); end
    @(posedge clk); #1;
  endtask

  task automatic test_directed64();
    int lat;
    send64(64'd5, 64'd7, OP_ADD);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (bus64.out_valid) break;
    end
    checks++;
    if (lat != 4) begin errors++; $display("FAIL lat64 got %0d exp 4", lat); end
    checks++;
    if ({bus64.out_flags, bus64.out_sum} !== {4'b0000, 64'd12}) begin
      errors++; $display("FAIL add5_7 got %b_%h exp 0000_c", bus64.out_flags, bus64.out_sum);
    end
    @(posedge clk); #1;
    send64(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, OP_ADD);
    send64(64'd3, 64'd3, OP_SUB);
    send64(64'd0, 64'd1, OP_SUB);
    send64(64'h0000_0000_FFFF_FFFF, 64'd1, OP_ADD);
    send64(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, OP_ADD);
    send64(64'h8000_0000_0000_0000, 64'd1, OP_SUB);
    wait_drain();
  endtask

  task automatic test_directed8();
    int lat;
    send8(8'd5, 8'd7, OP_ADD);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (bus8.out_valid) break;
    end
    checks++;
    if (lat != 1) begin errors++; $display("FAIL lat8 got %0d exp 1", lat); end
    @(posedge clk); #1;
    send8(8'd3, 8'd3, OP_SUB);
    send8(8'd0, 8'd1, OP_SUB);
    send8(8'h7F, 8'd1, OP_ADD);
    send8(8'hFF, 8'd1, OP_ADD);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    int start_pops;
    start_pops = pops64;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send64(64'h1111_1111_1111_1111 * 64'(i) + 64'hFFFF_FFF0, 64'(i * 3 + 1), i[0]);
      end
      begin
        logic [63:0] cap_sum;
        logic [3:0]  cap_flags;
        repeat (5) @(posedge clk);
        #1 bus64.out_ready = 1'b0;
        @(negedge clk);
        cap_sum   = bus64.out_sum;
        cap_flags = bus64.out_flags;
        checks++;
        if (bus64.out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid got %b exp 1", bus64.out_valid); end
        for (int c = 0; c < 3; c++) begin
          checks++;
          if (bus64.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got %b exp 0", bus64.in_ready); end
          checks++;
          if (bus64.out_sum !== cap_sum || bus64.out_flags !== cap_flags) begin
            errors++; $display("FAIL stall_stable got %h exp %h", bus64.out_sum, cap_sum);
          end
          @(posedge clk);
          if (c == 2) #1 bus64.out_ready = 1'b1;
          else @(negedge clk);
        end
      end
    join
    wait_drain();
    checks++;
    if (pops64 - start_pops != 8) begin
      errors++; $display("FAIL b2b_count got %0d exp 8", pops64 - start_pops);
    end
  endtask

  task automatic test_reset_flight();
    send64(64'd10, 64'd20, OP_ADD);
    send64(64'd30, 64'd40, OP_SUB);
    send64(64'd50, 64'd60, OP_ADD);
    rst = 1'b1;
    exp_q64.delete();
    exp_q8.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (bus64.out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0 at %0d", bus64.out_valid, i); end
      if (i == 0) begin
        checks++;
        if (bus64.in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got %b exp 1", bus64.in_ready); end
      end
      @(posedge clk); #1;
    end
    send64(64'd100, 64'd1, OP_ADD);
    wait_drain();
  endtask

  task automatic test_random();
    fork
      begin
        for (int i = 0; i < 40; i++)
          send64({$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'($urandom_range(0, 1)));
      end
      begin
        for (int i = 0; i < 40; i++)
          send8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      end
      begin
        for (int i = 0; i < 150; i++) begin
          @(posedge clk); #1;
          bus64.out_ready = 1'($urandom_range(0, 1));
          bus8.out_ready  = 1'($urandom_range(0, 1));
        end
      end
    join
    bus64.out_ready = 1'b1;
    bus8.out_ready  = 1'b1;
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_directed64();
    test_directed8();
    test_back_to_back();
    test_reset_flight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
